// File: rtl/cnt_pkg.sv
// Shared definitions for the cascade counter slice.
//   op_e      : the single operation applied to the whole counter in a cycle
//   MODE_WRAP : sat value for modulo wrap at the limits
//   MODE_SAT  : sat value for clamping at 0 / 2^W-1
package cnt_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_e;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage : cnt_pkg

// File: rtl/counter_slice.sv
// One SLICE_W-bit digit of the cascaded counter.
// Ports:
//   clk, rst_n         : shared clock, asynchronous active-low reset
//   din [SLICE_W-1:0]  : parallel load value for this digit
//   ld                 : load din (overrides everything else)
//   cin_up / bin_dn    : carry-in / borrow-in from the next lower digit
//   hold               : saturation freeze decided by the top level
//   q   [SLICE_W-1:0]  : registered digit value
//   cout_up / bout_dn  : combinational carry / borrow to the next digit
module counter_slice #(
  parameter int SLICE_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SLICE_W-1:0] din,
  input  logic               ld,
  input  logic               cin_up,
  input  logic               bin_dn,
  input  logic               hold,
  output logic [SLICE_W-1:0] q,
  output logic               cout_up,
  output logic               bout_dn
);

  // A digit passes the carry on only when it is about to roll over.
  assign cout_up = cin_up & (&q);
  assign bout_dn = bin_dn & ~(|q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ld) begin
      q <= din;
    end else if (hold) begin
      q <= q;
    end else if (cin_up) begin
      q <= q + SLICE_W'(1);
    end else if (bin_dn) begin
      q <= q - SLICE_W'(1);
    end
  end

endmodule : counter_slice

// File: rtl/cascade_counter.sv
// Synchronous up/down counter built from NUM_SLICES cascaded digits with
// combinational carry/borrow, optional saturation and overflow/underflow
// flags.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   en                    : global enable (flag clear works regardless)
//   ld, din [W-1:0]       : parallel load
//   incr, decr            : step requests (both together = hold)
//   sat                   : 0 = wrap at the limits, 1 = clamp
//   clr_flags             : clear the sticky flags
//   count [W-1:0]         : registered count
//   ovf, unf              : registered one-cycle limit pulses
//   ovf_sticky, unf_sticky: latched versions of the pulses
//   at_max, at_zero       : combinational limit decodes of count
module cascade_counter
  import cnt_pkg::*;
#(
  parameter int SLICE_W    = 2,
  parameter int NUM_SLICES = 4,
  localparam int W         = SLICE_W * NUM_SLICES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         ld,
  input  logic [W-1:0] din,
  input  logic         incr,
  input  logic         decr,
  input  logic         sat,
  input  logic         clr_flags,
  output logic [W-1:0] count,
  output logic         ovf,
  output logic         unf,
  output logic         ovf_sticky,
  output logic         unf_sticky,
  output logic         at_max,
  output logic         at_zero
);

  op_e                 op;
  logic                hold;
  logic [NUM_SLICES:0] carry;
  logic [NUM_SLICES:0] borrow;
  logic                ovf_p0;
  logic                unf_p0;

  always_comb begin
    op = OP_HOLD;
    if (!en)               op = OP_HOLD;
    else if (ld)           op = OP_LOAD;
    else if (incr && !decr) op = OP_UP;
    else if (decr && !incr) op = OP_DOWN;
    else                   op = OP_HOLD;
  end

  assign at_max  = &count;
  assign at_zero = ~(|count);

  // Clamping is a whole-counter decision: freezing every digit keeps the
  // partially propagated carry from corrupting the lower digits.
  assign hold = (sat == MODE_SAT) &&
                (((op == OP_UP) && at_max) || ((op == OP_DOWN) && at_zero));

  assign carry[0]  = (op == OP_UP);
  assign borrow[0] = (op == OP_DOWN);

  for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
    counter_slice #(
      .SLICE_W (SLICE_W)
    ) u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (din[k*SLICE_W +: SLICE_W]),
      .ld      (op == OP_LOAD),
      .cin_up  (carry[k]),
      .bin_dn  (borrow[k]),
      .hold    (hold),
      .q       (count[k*SLICE_W +: SLICE_W]),
      .cout_up (carry[k+1]),
      .bout_dn (borrow[k+1])
    );
  end

  // The carry out of the top digit is exactly "step up attempted at max".
  assign ovf_p0 = carry[NUM_SLICES];
  assign unf_p0 = borrow[NUM_SLICES];

  // ---- stage boundary: limit pulses and sticky flags ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf        <= 1'b0;
      unf        <= 1'b0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      ovf <= ovf_p0;
      unf <= unf_p0;
      // Set beats clear when both land in the same cycle.
      if (ovf_p0)         ovf_sticky <= 1'b1;
      else if (clr_flags) ovf_sticky <= 1'b0;
      if (unf_p0)         unf_sticky <= 1'b1;
      else if (clr_flags) unf_sticky <= 1'b0;
    end
  end

endmodule : cascade_counter

// File: tb/tb_cascade_counter.sv
module tb_cascade_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, ld, incr, decr, sat, clr_flags;
  logic [7:0] din;
  logic [7:0] count;
  logic       ovf, unf, ovf_sticky, unf_sticky, at_max, at_zero;

  // 9-bit regression instance
  logic       rst2_n;
  logic       en2, ld2, incr2, decr2, sat2, clr2;
  logic [8:0] din2;
  logic [8:0] count2;
  logic       ovf2, unf2, ovfs2, unfs2, atmax2, atzero2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cascade_counter dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ld(ld), .din(din),
    .incr(incr), .decr(decr), .sat(sat), .clr_flags(clr_flags),
    .count(count), .ovf(ovf), .unf(unf), .ovf_sticky(ovf_sticky),
    .unf_sticky(unf_sticky), .at_max(at_max), .at_zero(at_zero)
  );

  cascade_counter #(.SLICE_W(3), .NUM_SLICES(3)) dut9 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .ld(ld2), .din(din2),
    .incr(incr2), .decr(decr2), .sat(sat2), .clr_flags(clr2),
    .count(count2), .ovf(ovf2), .unf(unf2), .ovf_sticky(ovfs2),
    .unf_sticky(unfs2), .at_max(atmax2), .at_zero(atzero2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b1; ld = 1'b0; incr = 1'b0; decr = 1'b0; clr_flags = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; ld = 1'b0; din = 8'h00; incr = 1'b0;
    decr = 1'b0; sat = 1'b0; clr_flags = 1'b0;
    rst2_n = 1'b0; en2 = 1'b0; ld2 = 1'b0; din2 = 9'h000; incr2 = 1'b0;
    decr2 = 1'b0; sat2 = 1'b0; clr2 = 1'b0;
    #2;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_flags", {28'h0, ovf, unf, ovf_sticky, unf_sticky}, 32'h0);
    chk("rst_at_zero", 32'(at_zero), 32'h1);
    chk("rst_at_max", 32'(at_max), 32'h0);
    step();
    rst_n = 1'b1; rst2_n = 1'b1;

    // Full up-count with wrap
    idle(); incr = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      step();
      chk($sformatf("upcnt_%0d", i), 32'(count), 32'(i % 256));
      chk($sformatf("upovf_%0d", i), 32'(ovf), (i == 256) ? 32'h1 : 32'h0);
      if (i == 255) chk("upovfs_pre", 32'(ovf_sticky), 32'h0);
    end
    chk("upovfs_post", 32'(ovf_sticky), 32'h1);
    incr = 1'b0;
    step();
    chk("wrap_hold_cnt", 32'(count), 32'h0);
    chk("wrap_ovf_drop", 32'(ovf), 32'h0);
    chk("wrap_ovfs_keep", 32'(ovf_sticky), 32'h1);
    // clear works with en low
    en = 1'b0; clr_flags = 1'b1;
    step();
    chk("clr_en0", 32'(ovf_sticky), 32'h0);

    // Carry across slices
    idle(); ld = 1'b1; din = 8'h03;
    step();
    chk("ld03", 32'(count), 32'h03);
    ld = 1'b0; incr = 1'b1;
    step();
    chk("carry1", 32'(count), 32'h04);
    incr = 1'b0; ld = 1'b1; din = 8'h3F;
    step();
    ld = 1'b0; incr = 1'b1;
    step();
    chk("carry3", 32'(count), 32'h40);
    incr = 1'b0; decr = 1'b1;
    step();
    chk("borrow3", 32'(count), 32'h3F);

    // Load priority, incr+decr hold, en=0 hold
    idle(); ld = 1'b1; din = 8'hFF;
    step();
    chk("ldFF", 32'(count), 32'hFF);
    chk("at_max_FF", 32'(at_max), 32'h1);
    incr = 1'b1;
    step();
    chk("ld_over_incr", 32'(count), 32'hFF);
    chk("ld_no_ovf", 32'(ovf), 32'h0);
    ld = 1'b0; decr = 1'b1;
    step();
    chk("incdec_hold", 32'(count), 32'hFF);
    chk("incdec_no_ovf", 32'(ovf), 32'h0);
    decr = 1'b0; en = 1'b0;
    step();
    chk("en0_hold", 32'(count), 32'hFF);
    chk("en0_no_ovf", 32'(ovf), 32'h0);
    en = 1'b1; sat = 1'b1;
    step();
    chk("satup_cnt", 32'(count), 32'hFF);
    chk("satup_ovf", 32'(ovf), 32'h1);
    chk("satup_ovfs", 32'(ovf_sticky), 32'h1);
    incr = 1'b0;
    step();
    chk("satup_ovf_drop", 32'(ovf), 32'h0);

    // Saturated underflow, set beats clear
    idle(); ld = 1'b1; din = 8'h00;
    step();
    ld = 1'b0; decr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("satdn_cnt_%0d", i), 32'(count), 32'h0);
      chk($sformatf("satdn_unf_%0d", i), 32'(unf), 32'h1);
    end
    chk("satdn_unfs", 32'(unf_sticky), 32'h1);
    clr_flags = 1'b1;
    step();
    chk("set_wins", 32'(unf_sticky), 32'h1);
    decr = 1'b0;
    step();
    chk("clr_unfs", 32'(unf_sticky), 32'h0);
    chk("clr_keeps_ovfs0", 32'(ovf_sticky), 32'h0);
    // Wrap-mode underflow
    clr_flags = 1'b0; sat = 1'b0; decr = 1'b1;
    step();
    chk("wrapdn_cnt", 32'(count), 32'hFF);
    chk("wrapdn_unf", 32'(unf), 32'h1);
    step();
    chk("dn_cnt", 32'(count), 32'hFE);
    chk("dn_unf_drop", 32'(unf), 32'h0);

    // Asynchronous reset mid-count
    idle(); ld = 1'b1; din = 8'h5A;
    step();
    ld = 1'b0;
    chk("pre_rst_cnt", 32'(count), 32'h5A);
    chk("pre_rst_unfs", 32'(unf_sticky), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(count), 32'h0);
    chk("async_rst_flags", {28'h0, ovf, unf, ovf_sticky, unf_sticky}, 32'h0);
    #1 rst_n = 1'b1;
    incr = 1'b1;
    step();
    chk("post_rst_incr", 32'(count), 32'h1);
    incr = 1'b0;

    // 9-bit regression
    en2 = 1'b1; ld2 = 1'b1; din2 = 9'h1FF;
    step();
    chk("w9_ld", 32'(count2), 32'h1FF);
    chk("w9_at_max", 32'(atmax2), 32'h1);
    ld2 = 1'b0; incr2 = 1'b1;
    step();
    chk("w9_wrap", 32'(count2), 32'h0);
    chk("w9_ovf", 32'(ovf2), 32'h1);
    incr2 = 1'b0;
    step();
    chk("w9_ovf_drop", 32'(ovf2), 32'h0);
    chk("w9_ovfs", 32'(ovfs2), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_cascade_counter

// File: doc/cascade_counter.md
CASCADE_COUNTER -- requirements
Module: cascade_counter

Interface
REQ-001 Parameter SLICE_W, default 2, SHALL set the bit width of one counter slice.
REQ-002 Parameter NUM_SLICES, default 4, SHALL set the number of cascaded slices; the total width is W = SLICE_W*NUM_SLICES (8 by default).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 en  input  1  SHALL be the global enable; when low, all state holds except the sticky-flag clear.
REQ-006 ld  input  1  SHALL, when high, load din into count.
REQ-007 din  input  W  SHALL be the load value.
REQ-008 incr  input  1  SHALL request count+1.
REQ-009 decr  input  1  SHALL request count-1.
REQ-010 sat  input  1  SHALL select the limit mode: 0 = wrap, 1 = saturate at 0 or 2^W-1.
REQ-011 clr_flags  input  1  SHALL clear the sticky flags.
REQ-012 count  output  W  SHALL be the registered count value.
REQ-013 ovf  output  1  SHALL be a registered one-cycle pulse on an increment attempted at 2^W-1.
REQ-014 unf  output  1  SHALL be a registered one-cycle pulse on a decrement attempted at 0.
REQ-015 ovf_sticky  output  1  SHALL be a registered flag that latches ovf until it is cleared.
REQ-016 unf_sticky  output  1  SHALL be a registered flag that latches unf until it is cleared.
REQ-017 at_max  output  1  SHALL be combinational, high when count == 2^W-1.
REQ-018 at_zero  output  1  SHALL be combinational, high when count == 0.

Function
REQ-019 The operation SHALL be selected by priority: en=0 -> hold; ld -> load; incr&~decr -> up; decr&~incr -> down; incr&decr -> hold; otherwise hold.
REQ-020 The count SHALL take its new value one cycle after the inputs are sampled.
REQ-021 A load SHALL take precedence over incr/decr in the same cycle, and SHALL generate no ovf or unf pulse.
REQ-022 The carry and borrow SHALL propagate combinationally from slice 0 (LSB) to slice NUM_SLICES-1 within one cycle; all slices SHALL share clk, with no ripple clocking.
REQ-023 Slice k SHALL change only when its carry-in (up) or borrow-in (down) is asserted; the carry-in of slice 0 is the operation request.
REQ-024 Up at 2^W-1 with sat=0 -> count becomes 0 and ovf=1; with sat=1 -> count holds at 2^W-1 and ovf=1.
REQ-025 Down at 0 with sat=0 -> count becomes 2^W-1 and unf=1; with sat=1 -> count holds at 0 and unf=1.
REQ-026 ovf and unf SHALL be 0 in every cycle not covered by REQ-024 and REQ-025, including cycles with en=0.
REQ-027 Each sticky flag SHALL set on its pulse; clr_flags SHALL clear it regardless of en; if a set and a clear occur in the same cycle, the set SHALL win.
REQ-028 The arithmetic SHALL be unsigned modulo 2^W; no intermediate result SHALL exceed W+1 bits.

Reset
REQ-029 While rst_n=0, count SHALL be 0, and ovf, unf, ovf_sticky and unf_sticky SHALL be 0, asynchronously.
REQ-030 Assertion of reset in the middle of an operation SHALL abort it immediately; the first operation after release SHALL act on count=0.
REQ-031 Reset deassertion SHALL be treated as synchronous to clk by the integrator; the block SHALL add no synchronizer.

Structure
REQ-032 A shared package cnt_pkg SHALL hold the op encoding typedef (OP_HOLD, OP_LOAD, OP_UP, OP_DOWN) and the mode constants MODE_WRAP=0 and MODE_SAT=1.
REQ-033 A sub-module counter_slice SHALL be instantiated NUM_SLICES times in a generate loop.
REQ-034 counter_slice SHALL have ports clk, rst_n, SLICE_W-bit din, ld, cin_up, bin_dn, hold, a SLICE_W-bit q output, and combinational cout_up and bout_dn outputs.
REQ-035 The saturate and hold decision SHALL be made at the top level from at_max and at_zero, and fed to every slice as hold.
REQ-036 The design SHALL be legal for SLICE_W>=1 and NUM_SLICES>=1.

Verification
REQ-037 Reset, then en=1, incr=1 for 256 cycles (W=8, sat=0) -> count sequence 1..255,0; ovf pulses exactly once, at the wrap; ovf_sticky=1 from then on.
REQ-038 ld=1, din=8'h03, then incr=1 for 1 cycle -> count=8'h04 (carry into slice 1 checked); with din=8'h3F -> count=8'h40 (carry across 3 slices).
REQ-039 count=0, sat=1, decr=1 for 3 cycles -> count stays 0, unf=1 on each cycle, unf_sticky=1; clr_flags and unf asserted together -> unf_sticky stays 1.
REQ-040 ld=1, incr=1, din=8'hFF at count=8'hFF -> count=8'hFF, ovf=0; incr=1 and decr=1 -> count holds; en=0 with incr=1 -> count holds, ovf=0.
REQ-041 rst_n pulsed low mid-count (count=8'h5A) between clock edges -> count=0 and all flags 0 immediately; next incr -> count=1.
REQ-042 Regression with parameters SLICE_W=3 and NUM_SLICES=3 (W=9) -> incr from 9'h1FF gives 0 and ovf=1.
